conv1_pass_sequencer: RTL and testbench

Sequences the first convolution layer: four filter-group passes over the shared PE array, then a readback of the four result SRAM banks. It selects the active filter group and gates the PE array enable against input-row availability. It generates the bank write enables and addresses, then streams the stored rows out with a ready/valid handshake. It sits between the ifmap row buffer, the conv1 PE array/activation datapath, and the four conv1 result SRAM banks.

---
 rtl/conv1_pkg.sv | 29 ++
 rtl/conv1_rd_stream.sv | 67 ++++++
 rtl/conv1_pass_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_conv1_pass_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1_pkg.sv
// ============================================================================
//  Module      : conv1_pkg
//  Description : Shared definitions for the conv1 pass sequencer. This package
//                holds the FSM state encoding, the filter-group count and the
//                default geometry (rows per pass, PE pipeline latency, SRAM
//                address width).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WRITE = 3'd2,
        ST_NEXT  = 3'd3,
        ST_READ  = 3'd4,
        ST_DRAIN = 3'd5
    } conv1_state_e;

    localparam int CONV1_GROUPS   = 4;
    localparam int CONV1_OUT_ROWS = 32;
    localparam int CONV1_PIPE_LAT = 5;
    localparam int CONV1_ADDR_W   = 10;

endpackage

`default_nettype wire

// File: rtl/conv1_rd_stream.sv
// ============================================================================
//  Module      : conv1_rd_stream
//  Description : Readback address generator for the four conv1 result banks.
//                The read address advances only when downstream is ready. The
//                SRAM has one cycle of read latency, so out_vld and out_last
//                are registered copies of the issue strobe.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst_n     - clock, async active-low reset
//                i_active       - sequencer is in READ (and not aborting)
//                i_out_rdy      - downstream accepts a row next cycle
//                o_rd_cnt       - current read address
//                o_issue_last   - final address is being issued this cycle
//                o_out_vld      - bank read data valid (registered)
//                o_out_last     - final valid row (registered)
// ============================================================================
`default_nettype none

module conv1_rd_stream
    import conv1_pkg::*;
#(
    parameter int OUT_ROWS = CONV1_OUT_ROWS,
    parameter int CNT_W    = $clog2(OUT_ROWS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_active,
    input  logic             i_out_rdy,
    output logic [CNT_W-1:0] o_rd_cnt,
    output logic             o_issue_last,
    output logic             o_out_vld,
    output logic             o_out_last
);

    localparam logic [CNT_W-1:0] c_LAST_ROW = CNT_W'(OUT_ROWS - 1);

    logic [CNT_W-1:0] r_rd_cnt;
    logic             r_out_vld;
    logic             r_out_last;
    logic             w_issue;

    assign w_issue      = i_active & i_out_rdy;
    assign o_issue_last = w_issue & (r_rd_cnt == c_LAST_ROW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt   <= '0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
        end else begin
            // Counter is held at zero outside READ so every pass starts at row 0.
            if (!i_active) begin
                r_rd_cnt <= '0;
            end else if (w_issue) begin
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
            r_out_vld  <= w_issue;
            r_out_last <= o_issue_last;
        end
    end

    assign o_rd_cnt   = r_rd_cnt;
    assign o_out_vld  = r_out_vld;
    assign o_out_last = r_out_last;

endmodule

`default_nettype wire

// File: rtl/conv1_pass_sequencer.sv
// ============================================================================
//  Module      : conv1_pass_sequencer
//  Description : Sequences conv1: four filter-group passes over the shared PE
//                array (FILL the pipeline, WRITE activated rows to the group's
//                bank), then a ready/valid readback of the four result banks.
//                Optional macro CONV1_SEQ_ABORT_EN adds an i_abort input that
//                returns the block to IDLE from any busy state.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst_n      - clock, async active-low reset
//                i_start         - start request, sampled in IDLE only
//                i_row_avail     - ifmap row ready for the array
//                i_out_rdy       - downstream accepts a row next cycle
//                i_abort         - (CONV1_SEQ_ABORT_EN only) abort run
//                o_busy          - not in IDLE
//                o_grp_idx       - active filter group
//                o_pe_en/o_row_pop - PE enable / ifmap row consume
//                o_sram_we       - one-hot bank write enable
//                o_sram_addr     - shared bank address
//                o_out_vld/o_out_last - readback valid / final row
//                o_done          - completion pulse
// ============================================================================
`default_nettype none

module conv1_pass_sequencer
    import conv1_pkg::*;
#(
    parameter int OUT_ROWS = CONV1_OUT_ROWS,
    parameter int PIPE_LAT = CONV1_PIPE_LAT,
    parameter int ADDR_W   = CONV1_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_row_avail,
    input  logic                    i_out_rdy,
`ifdef CONV1_SEQ_ABORT_EN
    input  logic                    i_abort,
`endif
    output logic                    o_busy,
    output logic [1:0]              o_grp_idx,
    output logic                    o_pe_en,
    output logic                    o_row_pop,
    output logic [CONV1_GROUPS-1:0] o_sram_we,
    output logic [ADDR_W-1:0]       o_sram_addr,
    output logic                    o_out_vld,
    output logic                    o_out_last,
    output logic                    o_done
);

    localparam int CNT_W  = $clog2(OUT_ROWS) + 1;
    localparam int FILL_W = $clog2(PIPE_LAT) + 1;

    localparam logic [FILL_W-1:0] c_FILL_LAST = FILL_W'(PIPE_LAT - 1);
    localparam logic [CNT_W-1:0]  c_WR_LAST   = CNT_W'(OUT_ROWS - 1);
    localparam logic [1:0]        c_GRP_LAST  = 2'(CONV1_GROUPS - 1);

    conv1_state_e              r_state;
    conv1_state_e              w_state_nxt;
    logic [1:0]                r_grp;
    logic [FILL_W-1:0]         r_fill_cnt;
    logic [CNT_W-1:0]          r_wr_cnt;
    logic [CNT_W-1:0]          w_rd_cnt;
    logic                      w_rd_issue_last;
    logic                      w_rd_active;
    logic                      w_abort;
    logic                      w_pe_en;
    logic [CONV1_GROUPS-1:0]   w_sram_we;
    logic [ADDR_W-1:0]         w_sram_addr;

`ifdef CONV1_SEQ_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    // Suppress the issue strobe on an abort cycle so no stray out_vld appears
    // after the return to IDLE.
    assign w_rd_active = (r_state == ST_READ) & ~w_abort;

    conv1_rd_stream #(
        .OUT_ROWS (OUT_ROWS),
        .CNT_W    (CNT_W)
    ) u_rd_stream (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_active     (w_rd_active),
        .i_out_rdy    (i_out_rdy),
        .o_rd_cnt     (w_rd_cnt),
        .o_issue_last (w_rd_issue_last),
        .o_out_vld    (o_out_vld),
        .o_out_last   (o_out_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pe_en     = 1'b0;
        w_sram_we   = '0;
        w_sram_addr = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                w_pe_en = i_row_avail;
                if (i_row_avail && (r_fill_cnt == c_FILL_LAST)) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_pe_en          = i_row_avail;
                w_sram_we[r_grp] = i_row_avail;
                w_sram_addr      = ADDR_W'(r_wr_cnt);
                if (i_row_avail && (r_wr_cnt == c_WR_LAST)) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                w_state_nxt = (r_grp == c_GRP_LAST) ? ST_READ : ST_FILL;
            end
            ST_READ: begin
                w_sram_addr = ADDR_W'(w_rd_cnt);
                if (w_rd_issue_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grp      <= 2'd0;
            r_fill_cnt <= '0;
            r_wr_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;

            // Group index clears on entry to IDLE so it reads 0 whenever idle.
            if (w_state_nxt == ST_IDLE) begin
                r_grp <= 2'd0;
            end else if ((r_state == ST_NEXT) && (w_state_nxt == ST_FILL)) begin
                r_grp <= r_grp + 2'd1;
            end

            if (r_state != ST_FILL) begin
                r_fill_cnt <= '0;
            end else if (i_row_avail) begin
                r_fill_cnt <= r_fill_cnt + FILL_W'(1);
            end

            if (r_state != ST_WRITE) begin
                r_wr_cnt <= '0;
            end else if (i_row_avail) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
        end
    end

    assign o_busy      = (r_state != ST_IDLE);
    assign o_grp_idx   = r_grp;
    assign o_pe_en     = w_pe_en;
    assign o_row_pop   = w_pe_en;
    assign o_sram_we   = w_sram_we;
    assign o_sram_addr = w_sram_addr;
    // Completion coincides with the registered final-row strobe (DRAIN cycle).
    assign o_done      = o_out_last;

endmodule

`default_nettype wire

// File: tb/tb_conv1_pass_sequencer.sv
`default_nettype none

module tb_conv1_pass_sequencer;

    localparam int NC     = 1024;
    localparam int PL     = 5;
    localparam int N_ROWS = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       row_avail = 1'b0;
    logic       out_rdy = 1'b0;
    logic       abort = 1'b0;
    logic       busy;
    logic [1:0] grp_idx;
    logic       pe_en;
    logic       row_pop;
    logic [3:0] sram_we;
    logic [9:0] sram_addr;
    logic       out_vld;
    logic       out_last;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv1_pass_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_row_avail (row_avail),
        .i_out_rdy   (out_rdy),
`ifdef CONV1_SEQ_ABORT_EN
        .i_abort     (abort),
`endif
        .o_busy      (busy),
        .o_grp_idx   (grp_idx),
        .o_pe_en     (pe_en),
        .o_row_pop   (row_pop),
        .o_sram_we   (sram_we),
        .o_sram_addr (sram_addr),
        .o_out_vld   (out_vld),
        .o_out_last  (out_last),
        .o_done      (done)
    );

    // stimulus patterns indexed by cycle (cycle 0 = start cycle)
    bit ra_pat[NC];
    bit rdy_pat[NC];
    bit st_pat[NC];
    bit ab_pat[NC];
    // observed trace
    logic       l_busy[NC], l_pe[NC], l_pop[NC], l_vld[NC], l_last[NC], l_done[NC];
    logic [1:0] l_grp[NC];
    logic [3:0] l_we[NC];
    logic [9:0] l_addr[NC];
    // reference trace
    logic       e_busy[NC], e_pe[NC], e_vld[NC], e_last[NC], e_done[NC];
    logic [1:0] e_grp[NC];
    logic [3:0] e_we[NC];
    logic [9:0] e_addr[NC];

    task automatic clear_pats(input bit ones);
        for (int i = 0; i < NC; i++) begin
            ra_pat[i] = ones; rdy_pat[i] = ones; st_pat[i] = 1'b0; ab_pat[i] = 1'b0;
        end
        st_pat[0] = 1'b1;
    endtask

    task automatic run_seq(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            start = st_pat[c]; row_avail = ra_pat[c]; out_rdy = rdy_pat[c]; abort = ab_pat[c];
            #1;
            l_busy[c] = busy; l_grp[c] = grp_idx; l_pe[c] = pe_en; l_pop[c] = row_pop;
            l_we[c] = sram_we; l_addr[c] = sram_addr; l_vld[c] = out_vld;
            l_last[c] = out_last; l_done[c] = done;
        end
    endtask

    // Reference: each group pass consumes PL+N_ROWS row_avail-high cycles
    // (the last N_ROWS of them write rows 0..N_ROWS-1), followed by one gap
    // cycle; readback then needs N_ROWS out_rdy-high cycles, data one cycle
    // behind each accepted address, and completion lands with the last row.
    task automatic build_model(output int end_c);
        int c, en, k;
        for (int i = 0; i < NC; i++) begin
            e_busy[i] = 0; e_pe[i] = 0; e_vld[i] = 0; e_last[i] = 0; e_done[i] = 0;
            e_grp[i] = 0; e_we[i] = 0; e_addr[i] = 0;
        end
        c = 1;
        for (int g = 0; g < 4; g++) begin
            en = 0;
            while (en < PL + N_ROWS) begin
                e_busy[c] = 1; e_grp[c] = 2'(g); e_pe[c] = ra_pat[c];
                if (en >= PL) e_addr[c] = 10'(en - PL);
                if (ra_pat[c]) begin
                    if (en >= PL) e_we[c] = 4'(1 << g);
                    en++;
                end
                c++;
            end
            e_busy[c] = 1; e_grp[c] = 2'(g); c++;
        end
        k = 0;
        while (k < N_ROWS) begin
            e_busy[c] = 1; e_grp[c] = 2'd3; e_addr[c] = 10'(k);
            if (rdy_pat[c]) begin e_vld[c+1] = 1; k++; end
            c++;
        end
        e_busy[c] = 1; e_grp[c] = 2'd3; e_last[c] = 1; e_done[c] = 1;
        end_c = c;
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({busy, grp_idx, pe_en, row_pop, sram_we, sram_addr, out_vld, out_last, done} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {busy, grp_idx, pe_en, row_pop, sram_we, sram_addr, out_vld, out_last, done});
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal;
        int wi, nv, nd, nl, dc;
        clear_pats(1'b1);
        run_seq(190);
        wi = 0; nv = 0; nd = 0; nl = 0; dc = -1;
        for (int c = 0; c < 190; c++) begin
            if (l_we[c] != 4'd0) begin
                total++;
                if (l_we[c] !== 4'(1 << (wi / 32)) || l_addr[c] !== 10'(wi % 32)) begin
                    bad++;
                    $display("FAIL nom_write#%0d got we=%b addr=%0d exp we=%b addr=%0d",
                             wi, l_we[c], l_addr[c], 4'(1 << (wi / 32)), wi % 32);
                end
                wi++;
            end
            if (l_vld[c] === 1'b1) nv++;
            if (l_last[c] === 1'b1) nl++;
            if (l_done[c] === 1'b1) begin nd++; if (dc < 0) dc = c; end
        end
        total++; if (wi != 128) begin bad++; $display("FAIL nom_write_count got=%0d exp=128", wi); end
        total++; if (nv != 32)  begin bad++; $display("FAIL nom_vld_count got=%0d exp=32", nv); end
        total++; if (dc != 185) begin bad++; $display("FAIL nom_done_cycle got=%0d exp=185", dc); end
        total++; if (nd != 1)   begin bad++; $display("FAIL nom_done_count got=%0d exp=1", nd); end
        total++; if (nl != 1 || l_last[185] !== 1'b1) begin
            bad++; $display("FAIL nom_last got count=%0d at185=%b exp count=1 at185=1", nl, l_last[185]);
        end
    endtask

    task automatic test_row_stall;
        int n10, dc;
        clear_pats(1'b1);
        ra_pat[16] = 0; ra_pat[17] = 0; ra_pat[18] = 0;  // WRITE addr 10 of group 0
        run_seq(192);
        for (int c = 16; c <= 18; c++) begin
            total++;
            if (l_pe[c] !== 1'b0 || l_pop[c] !== 1'b0 || l_we[c] !== 4'd0) begin
                bad++;
                $display("FAIL stall_gate cyc=%0d got pe=%b pop=%b we=%b exp 0/0/0000", c, l_pe[c], l_pop[c], l_we[c]);
            end
        end
        n10 = 0; dc = -1;
        for (int c = 0; c < 192; c++) begin
            if (l_we[c] === 4'b0001 && l_addr[c] === 10'd10) n10++;
            if (l_done[c] === 1'b1 && dc < 0) dc = c;
        end
        total++; if (n10 != 1)  begin bad++; $display("FAIL stall_addr10_writes got=%0d exp=1", n10); end
        total++; if (dc != 188) begin bad++; $display("FAIL stall_done_cycle got=%0d exp=188", dc); end
    endtask

    task automatic test_rdy_toggle;
        int kk, ec, dc, nl;
        clear_pats(1'b1);
        for (int c = 0; c < NC; c++) rdy_pat[c] = (c % 2 == 0);
        build_model(ec);
        run_seq(ec + 3);
        kk = 0; dc = -1; nl = 0;
        for (int c = 1; c < ec + 3; c++) begin
            if (l_vld[c] === 1'b1) begin
                total++;
                if (l_addr[c-1] !== 10'(kk) || l_last[c] !== (kk == 31)) begin
                    bad++;
                    $display("FAIL rdy_pulse#%0d got addr=%0d last=%b exp addr=%0d last=%b",
                             kk, l_addr[c-1], l_last[c], kk, kk == 31);
                end
                kk++;
            end
            if (l_last[c] === 1'b1) nl++;
            if (l_done[c] === 1'b1 && dc < 0) dc = c;
        end
        total++; if (kk != 32) begin bad++; $display("FAIL rdy_vld_count got=%0d exp=32", kk); end
        total++; if (nl != 1)  begin bad++; $display("FAIL rdy_last_count got=%0d exp=1", nl); end
        total++; if (dc != ec) begin bad++; $display("FAIL rdy_done_cycle got=%0d exp=%0d", dc, ec); end
    endtask

    task automatic test_start_ignored;
        int nd, dc;
        clear_pats(1'b1);
        st_pat[20] = 1; st_pat[60] = 1; st_pat[100] = 1; st_pat[160] = 1; st_pat[185] = 1;
        run_seq(190);
        nd = 0; dc = -1;
        for (int c = 0; c < 190; c++)
            if (l_done[c] === 1'b1) begin nd++; if (dc < 0) dc = c; end
        total++; if (nd != 1 || dc != 185) begin
            bad++; $display("FAIL start_ign_done got count=%0d cyc=%0d exp count=1 cyc=185", nd, dc);
        end
        total++; if (l_grp[61] !== 2'd1 || l_grp[101] !== 2'd2) begin
            bad++; $display("FAIL start_ign_grp got g61=%0d g101=%0d exp 1/2", l_grp[61], l_grp[101]);
        end
        total++; if (l_busy[186] !== 1'b0 || l_busy[187] !== 1'b0) begin
            bad++; $display("FAIL start_ign_drain got busy186=%b busy187=%b exp 0/0", l_busy[186], l_busy[187]);
        end
    endtask

    task automatic test_mid_reset;
        int dc;
        clear_pats(1'b1);
        run_seq(88);  // cycle 87 = group 2, WRITE address 5
        total++; if (l_grp[87] !== 2'd2 || l_addr[87] !== 10'd5 || l_we[87] !== 4'b0100) begin
            bad++; $display("FAIL mrst_pre got grp=%0d addr=%0d we=%b exp 2/5/0100", l_grp[87], l_addr[87], l_we[87]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, grp_idx, pe_en, row_pop, sram_we, sram_addr, out_vld, out_last, done} !== 22'd0) begin
            bad++;
            $display("FAIL mrst_outputs got=%h exp=0",
                     {busy, grp_idx, pe_en, row_pop, sram_we, sram_addr, out_vld, out_last, done});
        end
        @(negedge clk); rst_n = 1'b1; start = 0;
        clear_pats(1'b1);
        run_seq(190);
        dc = -1;
        for (int c = 0; c < 190; c++) if (l_done[c] === 1'b1 && dc < 0) dc = c;
        total++; if (l_grp[1] !== 2'd0 || l_busy[1] !== 1'b1) begin
            bad++; $display("FAIL mrst_restart got grp=%0d busy=%b exp 0/1", l_grp[1], l_busy[1]);
        end
        total++; if (dc != 185) begin bad++; $display("FAIL mrst_done_cycle got=%0d exp=185", dc); end
    endtask

`ifdef CONV1_SEQ_ABORT_EN
    task automatic test_abort;
        int nd, dc;
        clear_pats(1'b1);
        ab_pat[40] = 1;  // FILL of group 1
        run_seq(45);
        nd = 0;
        for (int c = 0; c < 45; c++) if (l_done[c] === 1'b1) nd++;
        total++; if (l_busy[40] !== 1'b1 || l_grp[40] !== 2'd1) begin
            bad++; $display("FAIL abort_pre got busy=%b grp=%0d exp 1/1", l_busy[40], l_grp[40]);
        end
        total++; if (l_busy[41] !== 1'b0 || l_grp[41] !== 2'd0 || l_pe[41] !== 1'b0 || nd != 0) begin
            bad++; $display("FAIL abort_idle got busy=%b grp=%0d pe=%b dones=%0d exp 0/0/0/0",
                            l_busy[41], l_grp[41], l_pe[41], nd);
        end
        clear_pats(1'b1);
        run_seq(190);
        dc = -1; nd = 0;
        for (int c = 0; c < 190; c++) if (l_done[c] === 1'b1) begin nd++; if (dc < 0) dc = c; end
        total++; if (dc != 185 || nd != 1) begin
            bad++; $display("FAIL abort_rerun got cyc=%0d count=%0d exp 185/1", dc, nd);
        end
    endtask
`endif

    task automatic test_random;
        int ec;
        logic [21:0] got, exp;
        for (int it = 0; it < 5; it++) begin
            clear_pats(1'b0);
            for (int c = 0; c < NC; c++) begin
                ra_pat[c]  = (c >= 400) ? 1'b1 : ($urandom_range(3) != 0);
                rdy_pat[c] = (c >= 400) ? 1'b1 : ($urandom_range(2) != 0);
            end
            build_model(ec);
            for (int c = 1; c <= ec; c++) st_pat[c] = ($urandom_range(15) == 0);
            run_seq(ec + 3);
            for (int c = 0; c < ec + 3; c++) begin
                got = {l_busy[c], l_grp[c], l_pe[c], l_pop[c], l_we[c], l_addr[c], l_vld[c], l_last[c], l_done[c]};
                exp = {e_busy[c], e_grp[c], e_pe[c], e_pe[c], e_we[c], e_addr[c], e_vld[c], e_last[c], e_done[c]};
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL rand_trace it=%0d cyc=%0d got=%h exp=%h", it, c, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_row_stall();
        test_rdy_toggle();
        test_start_ignored();
        test_mid_reset();
`ifdef CONV1_SEQ_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
